// File: rtl/dmux_pkg.sv
// Shared encodings for the 1-to-N dispatcher.
// Imported by the dispatcher top and its one-hot decoder.
package dmux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic MODE_ROTATE   = 1'b0;
  localparam logic MODE_DIRECTED = 1'b1;

  localparam int XFER_W = 16;

endpackage

// File: rtl/dmux_onehot.sv
// Index-to-one-hot decoder with enable.
// Drives the per-channel valid lines of the dispatcher.
module dmux_onehot
  import dmux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [N-1:0]    onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/dmux_dispatch.sv
// Registered 1-to-N dispatcher: one-entry buffer,
// round-robin or directed destination, shared data bus.
module dmux_dispatch
  import dmux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_mode,
  input  logic [SELW-1:0]   in_sel,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SELW-1:0]   sel,
  output logic [XFER_W-1:0] xfer_count
);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] dest;
  logic            full;
  logic            done;
  logic            accept;
  logic            rotate;

  assign full   = (state == ST_FULL);
  assign done   = full && out_ready[sel];
  assign rotate = (in_mode == MODE_ROTATE);
  assign dest   = rotate ? ptr : in_sel;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = rst_n && (!full || out_ready[sel]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      ptr        <= '0;
      sel        <= '0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      if (accept) begin
        state    <= ST_FULL;
        out_data <= in_data;
        sel      <= dest;
        if (rotate) ptr <= ptr + 1'b1;
      end else if (done) begin
        state <= ST_EMPTY;
      end
      if (done) xfer_count <= xfer_count + 1'b1;
    end
  end

  dmux_onehot #(
    .N    (N),
    .SELW (SELW)
  ) u_onehot (
    .sel    (sel),
    .en     (full),
    .onehot (out_valid)
  );

endmodule

// File: tb/tb_dmux_dispatch.sv
// Directed bench for dmux_dispatch: vector table
// plus stall, reset and counter-wrap sequences.
module tb_dmux_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_mode;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic [1:0]  sel;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmux_dispatch #(.WIDTH(8), .N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel        (sel),
    .xfer_count (xfer_count)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        m;
    logic [1:0]  s;
    logic [3:0]  r;
    logic        ir;
    logic [3:0]  ov;
    logic [7:0]  od;
    logic [1:0]  os;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check in_ready before the edge,
  // registered outputs just after it.
  task automatic apply(input vec_t t, input string nm);
    @(negedge clk);
    in_valid  = t.v;
    in_data   = t.d;
    in_mode   = t.m;
    in_sel    = t.s;
    out_ready = t.r;
    #1;
    chk({nm, ".in_ready"}, in_ready, t.ir);
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, out_valid, t.ov);
    chk({nm, ".out_data"}, out_data, t.od);
    chk({nm, ".sel"}, sel, t.os);
    chk({nm, ".count"}, xfer_count, t.cnt);
  endtask

  initial begin
    vec_t h;
    // Rotate stream A0..A4, then idle
    tbl[0] = '{1, 8'hA0, 0, 0, 4'hF, 1, 4'b0001, 8'hA0, 0, 0};
    tbl[1] = '{1, 8'hA1, 0, 0, 4'hF, 1, 4'b0010, 8'hA1, 1, 1};
    tbl[2] = '{1, 8'hA2, 0, 0, 4'hF, 1, 4'b0100, 8'hA2, 2, 2};
    tbl[3] = '{1, 8'hA3, 0, 0, 4'hF, 1, 4'b1000, 8'hA3, 3, 3};
    tbl[4] = '{1, 8'hA4, 0, 0, 4'hF, 1, 4'b0001, 8'hA4, 0, 4};
    tbl[5] = '{0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'hA4, 0, 5};
    // Mixed: rotate, directed 3, rotate, idle
    tbl[6] = '{1, 8'h11, 0, 0, 4'hF, 1, 4'b0001, 8'h11, 0, 0};
    tbl[7] = '{1, 8'h22, 1, 3, 4'hF, 1, 4'b1000, 8'h22, 3, 1};
    tbl[8] = '{1, 8'h33, 0, 2, 4'hF, 1, 4'b0010, 8'h33, 1, 2};
    tbl[9] = '{0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 8'h33, 1, 3};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    in_sel    = 2'd0;
    out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.sel", sel, 0);
    chk("rst.count", xfer_count, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 6; i++) apply(tbl[i], "rot");

    // Directed word to 2, then stall with sink 2 not ready
    h = '{1, 8'h5A, 1, 2, 4'b1011, 1, 4'b0100, 8'h5A, 2, 5};
    apply(h, "dir");
    for (int i = 0; i < 10; i++) begin
      h = '{1, 8'hB0, 0, 0, 4'b1011, 0, 4'b0100, 8'h5A, 2, 5};
      apply(h, "stall");
    end
    h = '{0, 8'h00, 0, 0, 4'b0100, 1, 4'b0000, 8'h5A, 2, 6};
    apply(h, "drain");
    #1;
    chk("drain.empty_ready", in_ready, 1);

    // Rotate word lands on ptr=1; others ready, target not
    h = '{1, 8'hC1, 0, 0, 4'b1101, 1, 4'b0010, 8'hC1, 1, 6};
    apply(h, "nt_load");
    for (int i = 0; i < 3; i++) begin
      h = '{0, 8'h00, 0, 0, 4'b1101, 0, 4'b0010, 8'hC1, 1, 6};
      apply(h, "nontarget");
    end
    h = '{0, 8'h00, 0, 0, 4'b0010, 1, 4'b0000, 8'hC1, 1, 7};
    apply(h, "nt_done");

    // Async reset while holding a word for channel 2
    h = '{1, 8'h77, 1, 2, 4'b0000, 1, 4'b0100, 8'h77, 2, 7};
    apply(h, "pre_rst");
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", out_valid, 0);
    chk("arst.out_data", out_data, 0);
    chk("arst.sel", sel, 0);
    chk("arst.count", xfer_count, 0);
    chk("arst.in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 6; i < 10; i++) apply(tbl[i], "mixed");

    // Stream to push the counter through its wrap
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 8'hEE;
    out_ready = 4'hF;
    repeat (65533) @(posedge clk);
    #1;
    chk("wrap.ffff", xfer_count, 16'hFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap.zero", xfer_count, 0);
    chk("wrap.out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmux_dispatch.md
# dmux_dispatch

- Registered 1-to-N dispatcher that routes a single valid/ready input stream to one of N output channels.
- Provides the sequencing and sharing control around a plain demultiplexer: a one-entry holding buffer, a destination scheduler (round-robin or directed), and per-channel handshakes.
- Sits between a single producer and N consumers that share one broadcast data bus.

## Interface

Parameters:
- WIDTH, 8: data width in bits.
- N, 4: number of output channels; power of two, 2..8.
- SELW, $clog2(N): width of channel index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  dispatcher accepts the word this cycle.
- in_data  input  WIDTH  producer word.
- in_mode  input  1  0 = rotate (round-robin), 1 = directed; sampled on acceptance.
- in_sel  input  SELW  destination in directed mode; sampled on acceptance.
- out_valid  output  N  one-hot; bit k set means the word is offered to channel k.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  WIDTH  shared broadcast bus carrying the buffered word.
- sel  output  SELW  current/last destination index.
- xfer_count  output  16  completed output transfers; wraps.

## Operation

- FSM states are EMPTY and FULL.
- Input acceptance:
  - The input is accepted when in_valid && in_ready.
  - in_ready = (state==EMPTY) || (state==FULL && out_ready[sel]).
- Destination selection on acceptance:
  - Rotate mode: destination = ptr, then ptr ← ptr+1 mod N. ptr wraps N-1→0.
  - Directed mode: destination = in_sel; ptr is unchanged.
- On acceptance, buffer ← in_data, sel ← destination, state ← FULL.
- While FULL:
  - out_valid = one-hot(sel); out_data = buffer.
  - The output transfer completes when out_ready[sel]=1.
  - out_ready on non-selected channels is ignored.
- Transfer completion:
  - With no new acceptance in the same cycle: state ← EMPTY.
  - With a new acceptance in the same cycle: state stays FULL; buffer, sel and ptr take the new values; back-to-back throughput is 1 word/cycle.
- Stalled sink:
  - buffer, sel and out_valid hold indefinitely.
  - There is no reselection or timeout.
- While EMPTY:
  - out_valid = 0.
  - out_data and sel hold their last values (out_data = 0 after reset).
- xfer_count increments by 1 per completed output transfer and wraps 16'hFFFF→0.
- Reset (async assert, any state):
  - state=EMPTY, ptr=0, sel=0, out_valid=0, out_data=0, xfer_count=0.
  - A buffered word is dropped.
  - in_ready rises only after rst_n is released (first clock edge with rst_n=1 sees EMPTY).

## Timing

- Latency from input acceptance at edge t to out_valid at t+1: 1 cycle.
- in_ready has a combinational path from out_ready[sel]. There is no combinational path from in_valid to any output.
- out_valid, out_data, sel and xfer_count are registered.
- The two handshakes may complete in the same cycle (refill). Both effects apply at that edge.
- in_mode and in_sel are don't-care when no acceptance occurs.

## Structure

- Shared package dmux_pkg holds:
  - state encoding ST_EMPTY=1'b0, ST_FULL=1'b1;
  - mode encoding MODE_ROTATE=1'b0, MODE_DIRECTED=1'b1;
  - counter width XFER_W=16.
- Sub-module dmux_onehot (sel, en → N-bit one-hot) generates out_valid from sel gated by state==FULL. It is the natural reuse point for the team's existing demux cells.
- The FSM, ptr, buffer and counter live in dmux_dispatch.

## Test plan

- Reset then rotate:
  - Stimulus: N=4, mode 0, out_ready=4'hF, in_valid held high for 5 words A0..A4.
  - Required response: out_valid sequence 0001,0010,0100,1000,0001; one word per cycle; xfer_count=5.
- Directed and stall:
  - Stimulus: mode 1, in_sel=2, data 8'h5A, out_ready=4'b1011.
  - Required response: out_valid=0100 held; out_data=5A stable; in_ready=0 for 10 cycles.
  - Then raise out_ready[2]: transfer completes next edge, state EMPTY, in_ready=1.
- Mixed modes:
  - Stimulus: rotate (→0), directed in_sel=3, rotate.
  - Required response: destinations 0,3,1 (ptr unaffected by directed).
- Non-target ready:
  - Stimulus: FULL with sel=1, out_ready=4'b1101.
  - Required response: no transfer, count unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while FULL with out_valid=0100.
  - Required response: out_valid=0, out_data=0, sel=0, xfer_count=0 immediately.
  - Next rotate word goes to channel 0.
- Counter wrap:
  - Stimulus: force 65536 transfers.
  - Required response: xfer_count returns to 0.
